split: RTL and testbench

SPLIT -- requirements
Module: split

---
 rtl/split_pkg.sv | 21 ++
 rtl/split.sv | 115 +++++++++++
 tb/tb_split.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/split_pkg.sv
// Shared bus definitions for the address-split interconnect: request and
// response widths and the state encoding of the split FSM.
package split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    // Request word {valid, addr, wdata, wstrb}, MSB first; one strobe bit per byte.
    function automatic int bus_req_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response word {rdata, ready}, ready at bit 0.
    function automatic int bus_resp_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/split.sv
// One-master to N-slave address splitter. The top address bits pick the slave;
// the request is forwarded with zero added latency and the selection is held
// in sel_reg until the slave answers, a timeout fires, or reset.
//
// Handshake: a transfer completes on the cycle where the routed response has
// ready=1. The master holds its request stable until then; the splitter routes
// on the captured index (not the live address) for every cycle after the first.
module split
    import split_pkg::*;
#(
    parameter int N_SLAVES = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 0
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic [bus_req_w(ADDR_W, DATA_W)-1:0]                 m_req,
    output logic [bus_resp_w(DATA_W)-1:0]                        m_resp,
    output logic [N_SLAVES*bus_req_w(ADDR_W, DATA_W)-1:0]        s_req,
    input  logic [N_SLAVES*bus_resp_w(DATA_W)-1:0]               s_resp,
    output logic                                                 err
);

    localparam int REQ_W    = bus_req_w(ADDR_W, DATA_W);
    localparam int RESP_W   = bus_resp_w(DATA_W);
    localparam int P_SLAVES = $clog2(N_SLAVES);
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [P_SLAVES:0] N_LIMIT = (P_SLAVES + 1)'(N_SLAVES);

    state_t              state;
    logic [P_SLAVES-1:0] sel_reg;
    logic [TW-1:0]       timer;

    logic                m_valid;
    logic [P_SLAVES-1:0] idx;
    logic                idx_ok;
    logic                route_en;
    logic [P_SLAVES-1:0] route_idx;
    logic                sel_ready;

    assign m_valid = m_req[REQ_W-1];
    assign idx     = m_req[REQ_W-2 -: P_SLAVES];
    assign idx_ok  = {1'b0, idx} < N_LIMIT;
    assign err     = (state == ST_ERR) && !rst;

    // Route the request to one slave slice and the matching response back; all else zero.
    always_comb begin
        s_req     = '0;
        m_resp    = '0;
        route_en  = 1'b0;
        route_idx = sel_reg;
        sel_ready = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (m_valid && idx_ok) begin
                        route_en  = 1'b1;
                        route_idx = idx;
                    end
                end
                ST_BUSY: route_en = 1'b1;
                ST_ERR:  m_resp = RESP_W'(1);
                default: ;
            endcase
        end
        for (int i = 0; i < N_SLAVES; i++) begin
            if (route_en && route_idx == P_SLAVES'(i)) begin
                s_req[i*REQ_W +: REQ_W]  = m_req;
                m_resp                   = s_resp[i*RESP_W +: RESP_W];
                sel_ready                = s_resp[i*RESP_W];
            end
        end
    end

    // FSM: accept in IDLE, wait in BUSY for ready or timeout, one-cycle ERR response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sel_reg <= '0;
            timer   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m_valid) begin
                        if (idx_ok) begin
                            sel_reg <= idx;
                            if (!sel_ready) begin
                                state <= ST_BUSY;
                                timer <= '0;
                            end
                        end else begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_BUSY: begin
                    if (sel_ready) begin
                        state <= ST_IDLE;
                    end else if (TIMEOUT != 0) begin
                        if (timer == TW'(TO_LAST)) begin
                            state <= ST_ERR;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_split.sv
// Directed bench for the address splitter: a 4-slave instance with an 8-cycle
// timeout and a 3-slave instance without one.
module tb_split;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 4-slave instance signals
  logic        m_valid;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [REQ_W-1:0]    m_req4;
  logic [RESP_W-1:0]   m_resp4;
  logic [4*REQ_W-1:0]  s_req4;
  logic [4*RESP_W-1:0] s_resp4;
  logic                err4;
  logic [31:0] s_rdata[4];
  logic [3:0]  s_rdy;

  // 3-slave instance signals
  logic [REQ_W-1:0]    m_req3;
  logic [RESP_W-1:0]   m_resp3;
  logic [3*REQ_W-1:0]  s_req3;
  logic [3*RESP_W-1:0] s_resp3;
  logic                err3;

  assign m_req4 = {m_valid, m_addr, m_wdata, m_wstrb};

  always_comb begin
    s_resp4 = '0;
    for (int j = 0; j < 4; j++) s_resp4[j*RESP_W +: RESP_W] = {s_rdata[j], s_rdy[j]};
  end

  split #(.N_SLAVES(4), .ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) u4 (
    .clk(clk), .rst(rst), .m_req(m_req4), .m_resp(m_resp4),
    .s_req(s_req4), .s_resp(s_resp4), .err(err4));

  split #(.N_SLAVES(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) u3 (
    .clk(clk), .rst(rst), .m_req(m_req3), .m_resp(m_resp3),
    .s_req(s_req3), .s_resp(s_resp3), .err(err3));

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  rdy;
    logic [3:0]  exp_sv;
    logic        exp_rdy;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] sv4();
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = s_req4[i*REQ_W + REQ_W - 1];
    return m;
  endfunction

  function automatic logic [2:0] sv3();
    logic [2:0] m;
    for (int i = 0; i < 3; i++) m[i] = s_req3[i*REQ_W + REQ_W - 1];
    return m;
  endfunction

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic slaves_quiet();
    s_rdy = 4'h0;
    for (int j = 0; j < 4; j++) s_rdata[j] = 32'hD0D0_0000 + 32'(j);
  endtask

  initial begin
    m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    m_req3 = '0; s_resp3 = '0;
    slaves_quiet();

    // Reset: outputs are zero even with a ready slave and a valid request.
    tick();
    m_valid = 1'b1; m_addr = 32'h0000_0000; s_rdy = 4'hF;
    settle();
    check("rst_sv", 96'(sv4()), 96'(0));
    check("rst_mresp", 96'(m_resp4), 96'(0));
    check("rst_err", 96'(err4), 96'(0));
    tick();
    rst = 1'b0;
    m_valid = 1'b0; s_rdy = 4'h0;

    // Single-cycle IDLE transfers (slave ready in the accept cycle).
    vecs[0] = '{1'b0, 32'h4000_0010, 32'h0,         4'h0, 4'hF, 4'b0000, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF, 4'b0010, 4'b0010, 1'b1, 32'hD0D0_0001};
    vecs[2] = '{1'b0, 32'h4000_0010, 32'h0,         4'h0, 4'b0010, 4'b0000, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 32'h0000_0004, 32'hCAFE_0000, 4'h3, 4'b0001, 4'b0001, 1'b1, 32'hD0D0_0000};
    vecs[4] = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 4'b1111, 4'b0100, 1'b1, 32'hD0D0_0002};
    vecs[5] = '{1'b1, 32'hFFFF_FFFC, 32'h5555_AAAA, 4'h8, 4'b1000, 4'b1000, 1'b1, 32'hD0D0_0003};
    vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'h0,         4'h0, 4'b0011, 4'b0010, 1'b1, 32'hD0D0_0001};

    for (int v = 0; v < 7; v++) begin
      m_valid = vecs[v].valid; m_addr = vecs[v].addr;
      m_wdata = vecs[v].wdata; m_wstrb = vecs[v].wstrb;
      s_rdy = vecs[v].rdy;
      settle();
      check($sformatf("vec%0d_sv", v), 96'(sv4()), 96'(vecs[v].exp_sv));
      check($sformatf("vec%0d_rdy", v), 96'(m_resp4[0]), 96'(vecs[v].exp_rdy));
      check($sformatf("vec%0d_rdata", v), 96'(m_resp4[32:1]), 96'(vecs[v].exp_rdata));
      check($sformatf("vec%0d_err", v), 96'(err4), 96'(0));
      if (vecs[v].valid) begin
        int k;
        k = int'(vecs[v].addr[31:30]);
        check($sformatf("vec%0d_fwd", v), 96'(s_req4[k*REQ_W +: REQ_W]),
              96'({1'b1, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb}));
      end
      tick();
    end
    m_valid = 1'b0; slaves_quiet();

    // Read to slave 3, ready three cycles after accept.
    m_valid = 1'b1; m_addr = 32'hC000_0000; m_wdata = '0; m_wstrb = 4'h0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin s_rdy = 4'b1000; s_rdata[3] = 32'hA5A5_0001; end
      settle();
      check($sformatf("rd3_c%0d_sv", c), 96'(sv4()), 96'(4'b1000));
      check($sformatf("rd3_c%0d_rdy", c), 96'(m_resp4[0]), 96'(c == 3));
      if (c == 3) check("rd3_rdata", 96'(m_resp4[32:1]), 96'(32'hA5A5_0001));
      tick();
    end
    m_valid = 1'b0; slaves_quiet();
    settle();
    check("rd3_idle_resp", 96'(m_resp4), 96'(0));
    check("rd3_idle_sv", 96'(sv4()), 96'(0));
    tick();

    // Timeout: slave 2 never answers; 8 BUSY cycles then ERR, late ready ignored.
    m_valid = 1'b1; m_addr = 32'h8000_0000;
    for (int c = 0; c <= 8; c++) begin
      settle();
      check($sformatf("to_c%0d_sv", c), 96'(sv4()), 96'(4'b0100));
      check($sformatf("to_c%0d_err", c), 96'(err4), 96'(0));
      tick();
    end
    settle();
    check("to_err_pulse", 96'(err4), 96'(1));
    check("to_err_resp", 96'(m_resp4), 96'(1));
    check("to_err_sv", 96'(sv4()), 96'(0));
    tick();
    m_valid = 1'b0; s_rdy = 4'b0100; s_rdata[2] = 32'hBEEF_0002;
    settle();
    check("to_late_resp", 96'(m_resp4), 96'(0));
    check("to_late_err", 96'(err4), 96'(0));
    tick();
    slaves_quiet();

    // Reset during BUSY abandons the transaction.
    m_valid = 1'b1; m_addr = 32'h4000_0000;
    tick();
    settle();
    check("rb_busy_sv", 96'(sv4()), 96'(4'b0010));
    rst = 1'b1;
    tick();
    rst = 1'b0; m_valid = 1'b0; s_rdy = 4'b0010; s_rdata[1] = 32'h1111_2222;
    settle();
    check("rb_after_resp", 96'(m_resp4), 96'(0));
    check("rb_after_sv", 96'(sv4()), 96'(0));
    tick();
    slaves_quiet();

    // Decode error on the 3-slave instance: index 3 does not exist.
    m_req3 = {1'b1, 32'hC000_0000, 32'h0, 4'h0};
    s_resp3 = {33'h1_0000_0003, 33'h1_0000_0005, 33'h1_0000_0007};
    settle();
    check("dec_sv", 96'(sv3()), 96'(0));
    check("dec_c0_resp", 96'(m_resp3), 96'(0));
    check("dec_c0_err", 96'(err3), 96'(0));
    tick();
    m_req3 = '0;
    settle();
    check("dec_c1_resp", 96'(m_resp3), 96'(1));
    check("dec_c1_err", 96'(err3), 96'(1));
    check("dec_c1_sv", 96'(sv3()), 96'(0));
    tick();
    settle();
    check("dec_c2_err", 96'(err3), 96'(0));
    s_resp3 = '0;
    tick();

    // Random back-to-back traffic with noisy non-selected slaves and a moving address.
    for (int t = 0; t < 30; t++) begin
      logic [1:0]  kk;
      logic [31:0] data;
      int d;
      kk = 2'($urandom_range(0, 3));
      d = $urandom_range(0, 3);
      data = $urandom;
      m_valid = 1'b1; m_addr = {kk, 30'($urandom)}; m_wdata = $urandom; m_wstrb = 4'($urandom);
      exp_q.push_back(data);
      for (int c = 0; c <= d; c++) begin
        for (int j = 0; j < 4; j++) begin
          if (j == int'(kk)) begin
            s_rdy[j] = (c == d);
            s_rdata[j] = data;
          end else begin
            s_rdy[j] = 1'($urandom_range(0, 1));
            s_rdata[j] = $urandom;
          end
        end
        settle();
        check($sformatf("rnd%0d_c%0d_sv", t, c), 96'(sv4()), 96'(4'b0001 << kk));
        check($sformatf("rnd%0d_c%0d_rdy", t, c), 96'(m_resp4[0]), 96'(c == d));
        if (c == d) begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check($sformatf("rnd%0d_rdata", t), 96'(m_resp4[32:1]), 96'(e));
        end
        tick();
        m_addr[31:30] = 2'($urandom_range(0, 3));
      end
    end
    m_valid = 1'b0; slaves_quiet();
    settle();
    check("rnd_end_resp", 96'(m_resp4), 96'(0));
    check("rnd_queue_empty", 96'(exp_q.size()), 96'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
